// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60Hz raster constants and coordinate type, used by the timing,
// pixel-colour and game-logic stages.
package vga_timing_pkg;

    localparam int unsigned COORD_W     = 10;
    localparam int unsigned CLK_DIV     = 4;

    localparam int unsigned H_TOTAL     = 800;
    localparam int unsigned H_SYNC      = 96;
    localparam int unsigned H_VIS_START = 144;
    localparam int unsigned H_VIS_END   = 784;

    localparam int unsigned V_TOTAL     = 525;
    localparam int unsigned V_SYNC      = 2;
    localparam int unsigned V_VIS_START = 35;
    localparam int unsigned V_VIS_END   = 515;

    typedef logic [COORD_W-1:0] coord_t;

    // Half-open window test [lo, hi)
    function automatic logic in_span(input coord_t c, input coord_t lo, input coord_t hi);
        return (c >= lo) && (c < hi);
    endfunction

endpackage

// File: rtl/vga_pix_en_div.sv
// Clock divider producing a registered one-clock pix_en pulse every CLK_DIV clocks.
module vga_pix_en_div
    import vga_timing_pkg::*;
#(
    parameter int unsigned CLK_DIV = vga_timing_pkg::CLK_DIV
) (
    input  logic clk,
    input  logic rst_n,
    output logic pix_en
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] div_nx;

    always_comb begin
        div_nx = (div == DIV_LAST) ? '0 : div + DIV_W'(1);
    end

    // pix_en is registered from the next divider value so it is high while div==CLK_DIV-1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div    <= '0;
            pix_en <= 1'b0;
        end else begin
            div    <= div_nx;
            pix_en <= (div_nx == DIV_LAST);
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel counters, sync/blanking decode, frame strobe.
// Optional 16-bit frame counter port when VGA_TIMING_FRAME_CNT_EN is defined.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned CLK_DIV     = vga_timing_pkg::CLK_DIV,
    parameter int unsigned H_TOTAL     = vga_timing_pkg::H_TOTAL,
    parameter int unsigned H_SYNC      = vga_timing_pkg::H_SYNC,
    parameter int unsigned H_VIS_START = vga_timing_pkg::H_VIS_START,
    parameter int unsigned H_VIS_END   = vga_timing_pkg::H_VIS_END,
    parameter int unsigned V_TOTAL     = vga_timing_pkg::V_TOTAL,
    parameter int unsigned V_SYNC      = vga_timing_pkg::V_SYNC,
    parameter int unsigned V_VIS_START = vga_timing_pkg::V_VIS_START,
    parameter int unsigned V_VIS_END   = vga_timing_pkg::V_VIS_END
) (
    input  logic        clk,
    input  logic        Reset_n,
    output logic        pix_en,
    output coord_t      hCount,
    output coord_t      vCount,
    output logic        hSync,
    output logic        vSync,
    output logic        bright,
    output logic        frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
   ,output logic [15:0] frame_cnt
`endif
);

    coord_t h_nx;
    coord_t v_nx;
    logic   h_wrap;
    logic   v_wrap;
    logic   frame_wrap;

    vga_pix_en_div #(
        .CLK_DIV(CLK_DIV)
    ) u_div (
        .clk   (clk),
        .rst_n (Reset_n),
        .pix_en(pix_en)
    );

    always_comb begin
        h_wrap     = (hCount == coord_t'(H_TOTAL - 1));
        v_wrap     = (vCount == coord_t'(V_TOTAL - 1));
        frame_wrap = pix_en && h_wrap && v_wrap;
        h_nx       = hCount;
        v_nx       = vCount;
        if (pix_en) begin
            if (h_wrap) begin
                h_nx = '0;
                v_nx = v_wrap ? '0 : vCount + coord_t'(1);
            end else begin
                h_nx = hCount + coord_t'(1);
            end
        end
    end

    // Decode from next counter values so sync/bright share the counters' edge
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            hCount      <= '0;
            vCount      <= '0;
            hSync       <= 1'b0;
            vSync       <= 1'b0;
            bright      <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            hCount      <= h_nx;
            vCount      <= v_nx;
            hSync       <= (h_nx >= coord_t'(H_SYNC));
            vSync       <= (v_nx >= coord_t'(V_SYNC));
            bright      <= in_span(h_nx, coord_t'(H_VIS_START), coord_t'(H_VIS_END)) &&
                           in_span(v_nx, coord_t'(V_VIS_START), coord_t'(V_VIS_END));
            frame_start <= frame_wrap;
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            frame_cnt <= '0;
        end else if (frame_wrap) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: a full-size and a shrunken-raster instance checked every clock
// against an analytic model derived from the clock count since reset release.
module tb_vga_timing_gen;
    import vga_timing_pkg::*;

    localparam int unsigned S_HT = 40, S_HSY = 6, S_HVS = 10, S_HVE = 34;
    localparam int unsigned S_VT = 20, S_VSY = 2, S_VVS = 4,  S_VVE = 17;
    localparam int unsigned S_FRAME_CLKS = S_HT * S_VT * 4;

    typedef logic [40:0] vec_t; // {fc[15:0], pe, h[9:0], v[9:0], hs, vs, br, fs}
    typedef struct {
        string tag;
        vec_t  exp;
    } sb_t;

    logic   clk = 1'b0;
    logic   Reset_n = 1'b0;

    logic   pix_en_d, hSync_d, vSync_d, bright_d, frame_start_d;
    coord_t hCount_d, vCount_d;
    logic   pix_en_s, hSync_s, vSync_s, bright_s, frame_start_s;
    coord_t hCount_s, vCount_s;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] frame_cnt_d, frame_cnt_s;
    logic [15:0] fc_base_s = '0;
`endif

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned k = 0;
    sb_t sb_q[$];

    logic        stats_on = 1'b0;
    int unsigned hs_low = 0, vs_low = 0, br_s_clks = 0, fs_pulses = 0;
    logic        fs_seen = 1'b0;
    int unsigned last_fs_k = 0;

    always #5 clk = ~clk;

    vga_timing_gen dut (
        .clk        (clk),
        .Reset_n    (Reset_n),
        .pix_en     (pix_en_d),
        .hCount     (hCount_d),
        .vCount     (vCount_d),
        .hSync      (hSync_d),
        .vSync      (vSync_d),
        .bright     (bright_d),
        .frame_start(frame_start_d)
`ifdef VGA_TIMING_FRAME_CNT_EN
       ,.frame_cnt  (frame_cnt_d)
`endif
    );

    vga_timing_gen #(
        .CLK_DIV    (4),
        .H_TOTAL    (S_HT),
        .H_SYNC     (S_HSY),
        .H_VIS_START(S_HVS),
        .H_VIS_END  (S_HVE),
        .V_TOTAL    (S_VT),
        .V_SYNC     (S_VSY),
        .V_VIS_START(S_VVS),
        .V_VIS_END  (S_VVE)
    ) dut_s (
        .clk        (clk),
        .Reset_n    (Reset_n),
        .pix_en     (pix_en_s),
        .hCount     (hCount_s),
        .vCount     (vCount_s),
        .hSync      (hSync_s),
        .vSync      (vSync_s),
        .bright     (bright_s),
        .frame_start(frame_start_s)
`ifdef VGA_TIMING_FRAME_CNT_EN
       ,.frame_cnt  (frame_cnt_s)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected outputs after k clock edges since reset release
    function automatic vec_t model(input int unsigned kk, input int unsigned ht, input int unsigned hsy,
                                   input int unsigned hvs, input int unsigned hve, input int unsigned vt,
                                   input int unsigned vsy, input int unsigned vvs, input int unsigned vve);
        int unsigned steps, p, h, v;
        vec_t r;
        steps   = kk / 4;
        p       = steps % (ht * vt);
        h       = p % ht;
        v       = p / ht;
        r       = '0;
        r[40:25] = 16'(steps / (ht * vt));
        r[24]    = (kk % 4) == 3;
        r[23:14] = 10'(h);
        r[13:4]  = 10'(v);
        r[3]     = h >= hsy;
        r[2]     = v >= vsy;
        r[1]     = (h >= hvs) && (h < hve) && (v >= vvs) && (v < vve);
        r[0]     = ((kk % 4) == 0) && (steps != 0) && (p == 0);
        return r;
    endfunction

    function automatic vec_t obs_d();
        logic [15:0] fc;
`ifdef VGA_TIMING_FRAME_CNT_EN
        fc = frame_cnt_d;
`else
        fc = '0;
`endif
        return {fc, pix_en_d, hCount_d, vCount_d, hSync_d, vSync_d, bright_d, frame_start_d};
    endfunction

    function automatic vec_t obs_s();
        logic [15:0] fc;
`ifdef VGA_TIMING_FRAME_CNT_EN
        fc = frame_cnt_s;
`else
        fc = '0;
`endif
        return {fc, pix_en_s, hCount_s, vCount_s, hSync_s, vSync_s, bright_s, frame_start_s};
    endfunction

    task automatic push_expected();
        sb_t e;
        e.tag = $sformatf("full@k%0d", k);
        e.exp = model(k, 800, 96, 144, 784, 525, 2, 35, 515);
`ifndef VGA_TIMING_FRAME_CNT_EN
        e.exp[40:25] = '0;
`endif
        sb_q.push_back(e);
        e.tag = $sformatf("small@k%0d", k);
        e.exp = model(k, S_HT, S_HSY, S_HVS, S_HVE, S_VT, S_VSY, S_VVS, S_VVE);
`ifdef VGA_TIMING_FRAME_CNT_EN
        e.exp[40:25] = e.exp[40:25] + fc_base_s;
`else
        e.exp[40:25] = '0;
`endif
        sb_q.push_back(e);
    endtask

    task automatic pop_and_compare();
        sb_t e;
        if (sb_q.size() != 2) begin
            check("sb_depth", 64'(sb_q.size()), 64'd2);
        end else begin
            e = sb_q.pop_front();
            check(e.tag, 64'(obs_d()), 64'(e.exp));
            e = sb_q.pop_front();
            check(e.tag, 64'(obs_s()), 64'(e.exp));
        end
    endtask

    task automatic sample();
        push_expected();
        pop_and_compare();
        if (frame_start_s) begin
            if (fs_seen) check("fs_period", 64'(k - last_fs_k), 64'(S_FRAME_CLKS));
            fs_seen   = 1'b1;
            last_fs_k = k;
        end
        if (stats_on) begin
            if (k < 3200 && !hSync_d)  hs_low++;
            if (!vSync_d)              vs_low++;
            if (k < S_FRAME_CLKS && bright_s) br_s_clks++;
            if (frame_start_s)         fs_pulses++;
        end
    endtask

    task automatic run_cycles(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            sample();
        end
    endtask

    initial begin
        k = 0;
        repeat (3) begin
            @(negedge clk);
            sample();
        end
        Reset_n  = 1'b1;
        stats_on = 1'b1;
        sample();
        run_cycles(10000);

`ifdef VGA_TIMING_FRAME_CNT_EN
        // Preload 0xFFFF between edges so the next frame strobe must wrap to zero
        force dut_s.frame_cnt = 16'hFFFF;
        #1;
        release dut_s.frame_cnt;
        fc_base_s = 16'hFFFF - 16'(k / S_FRAME_CLKS);
        check("fc_forced", 64'(frame_cnt_s), 64'hFFFF);
`endif

        // Stop with the full raster at (400,11), two clocks into the pixel
        run_cycles(26802);
        stats_on = 1'b0;
        check("hsync_low_clks", 64'(hs_low), 64'd384);
        check("vsync_low_clks", 64'(vs_low), 64'd6400);
        check("bright_clks_small", 64'(br_s_clks), 64'(24 * 13 * 4));
        check("fs_pulses_small", 64'(fs_pulses), 64'd11);
        check("mid_h_before_rst", 64'(hCount_d), 64'd400);
        check("mid_v_before_rst", 64'(vCount_d), 64'd11);

        #1;
        Reset_n = 1'b0;
        #1;
        k       = 0;
        fs_seen = 1'b0;
`ifdef VGA_TIMING_FRAME_CNT_EN
        fc_base_s = '0;
`endif
        sample();
        repeat (3) begin
            @(negedge clk);
            sample();
        end
        Reset_n   = 1'b1;
        fs_pulses = 0;
        sample();
        run_cycles(2 * S_FRAME_CLKS + 200);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
